// File: rtl/vector_loader.sv
// vector_loader: buffers four A-row and four B-column sparse packets, then streams all
// 16 row/column pairs row-major. Optional packet size check: VECTOR_LOADER_SIZE_CHECK_EN.
module vector_loader #(
    parameter int DATA_W = 16,
    localparam int VEC_W = 4 * DATA_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pkt_valid,
    input  logic [2*VEC_W+7:0] pkt_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [VEC_W-1:0]   a_vals,
    output logic [VEC_W-1:0]   a_idx,
    output logic [VEC_W-1:0]   b_vals,
    output logic [VEC_W-1:0]   b_idx,
    output logic [2:0]         a_nnz,
    output logic [2:0]         b_nnz,
    output logic [1:0]         row,
    output logic [1:0]         col,
    output logic               busy,
    output logic               done,
    output logic               overrun,
    output logic               size_err
);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        ISSUE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic [1:0] load_cnt_q, load_cnt_d;
    logic [1:0] row_q, row_d;
    logic [1:0] col_q, col_d;
    logic       overrun_q, overrun_d;
    logic       size_err_q, size_err_d;

    logic [VEC_W-1:0] slot_a_vals_q [4];
    logic [VEC_W-1:0] slot_a_vals_d [4];
    logic [VEC_W-1:0] slot_a_idx_q  [4];
    logic [VEC_W-1:0] slot_a_idx_d  [4];
    logic [2:0]       slot_a_nnz_q  [4];
    logic [2:0]       slot_a_nnz_d  [4];
    logic [VEC_W-1:0] slot_b_vals_q [4];
    logic [VEC_W-1:0] slot_b_vals_d [4];
    logic [VEC_W-1:0] slot_b_idx_q  [4];
    logic [VEC_W-1:0] slot_b_idx_d  [4];
    logic [2:0]       slot_b_nnz_q  [4];
    logic [2:0]       slot_b_nnz_d  [4];

    logic [VEC_W-1:0] out_a_vals_q, out_a_vals_d;
    logic [VEC_W-1:0] out_a_idx_q,  out_a_idx_d;
    logic [VEC_W-1:0] out_b_vals_q, out_b_vals_d;
    logic [VEC_W-1:0] out_b_idx_q,  out_b_idx_d;
    logic [2:0]       out_a_nnz_q,  out_a_nnz_d;
    logic [2:0]       out_b_nnz_q,  out_b_nnz_d;

    logic [7:0]       pkt_size;
    logic [VEC_W-1:0] pkt_vals;
    logic [VEC_W-1:0] pkt_idx;
    logic [2:0]       pkt_nnz;
    logic             pkt_reject;
    logic             load_issue;

    // size counts value bytes, two per element
    assign pkt_size = pkt_data[2*VEC_W +: 8];
    assign pkt_vals = pkt_data[VEC_W +: VEC_W];
    assign pkt_idx  = pkt_data[0 +: VEC_W];
    assign pkt_nnz  = pkt_size[3:1];

`ifdef VECTOR_LOADER_SIZE_CHECK_EN
    assign pkt_reject = pkt_size[0] || (pkt_size > 8'd8);
`else
    logic unused_size_bits;
    assign unused_size_bits = ^{pkt_size[7:4], pkt_size[0]};
    assign pkt_reject = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        load_cnt_d    = load_cnt_q;
        row_d         = row_q;
        col_d         = col_q;
        overrun_d     = overrun_q;
        size_err_d    = 1'b0;
        load_issue    = 1'b0;
        slot_a_vals_d = slot_a_vals_q;
        slot_a_idx_d  = slot_a_idx_q;
        slot_a_nnz_d  = slot_a_nnz_q;
        slot_b_vals_d = slot_b_vals_q;
        slot_b_idx_d  = slot_b_idx_q;
        slot_b_nnz_d  = slot_b_nnz_q;
        out_a_vals_d  = out_a_vals_q;
        out_a_idx_d   = out_a_idx_q;
        out_a_nnz_d   = out_a_nnz_q;
        out_b_vals_d  = out_b_vals_q;
        out_b_idx_d   = out_b_idx_q;
        out_b_nnz_d   = out_b_nnz_q;

        case (state_q)
            LOAD_A, LOAD_B: begin
                if (pkt_valid && pkt_reject) begin
                    size_err_d = 1'b1;
                end else if (pkt_valid) begin
                    if (state_q == LOAD_A) begin
                        slot_a_vals_d[load_cnt_q] = pkt_vals;
                        slot_a_idx_d[load_cnt_q]  = pkt_idx;
                        slot_a_nnz_d[load_cnt_q]  = pkt_nnz;
                    end else begin
                        slot_b_vals_d[load_cnt_q] = pkt_vals;
                        slot_b_idx_d[load_cnt_q]  = pkt_idx;
                        slot_b_nnz_d[load_cnt_q]  = pkt_nnz;
                    end
                    load_cnt_d = load_cnt_q + 2'd1;
                    if (load_cnt_q == 2'd3) begin
                        if (state_q == LOAD_A) begin
                            state_d = LOAD_B;
                        end else begin
                            state_d    = ISSUE;
                            row_d      = 2'd0;
                            col_d      = 2'd0;
                            load_issue = 1'b1;
                        end
                    end
                end
            end
            ISSUE: begin
                if (pkt_valid) begin
                    overrun_d = 1'b1;
                end
                if (out_ready) begin
                    col_d = col_q + 2'd1;
                    if (col_q == 2'd3) begin
                        row_d = row_q + 2'd1;
                    end
                    if (row_q == 2'd3 && col_q == 2'd3) begin
                        state_d = DONE;
                    end else begin
                        load_issue = 1'b1;
                    end
                end
            end
            DONE: begin
                if (pkt_valid) begin
                    overrun_d = 1'b1;
                end
                state_d    = LOAD_A;
                load_cnt_d = 2'd0;
            end
            default: begin
                state_d = LOAD_A;
            end
        endcase

        // Slot 0 of B is never the slot written on the entry edge, so no bypass is needed.
        if (load_issue) begin
            out_a_vals_d = slot_a_vals_q[row_d];
            out_a_idx_d  = slot_a_idx_q[row_d];
            out_a_nnz_d  = slot_a_nnz_q[row_d];
            out_b_vals_d = slot_b_vals_q[col_d];
            out_b_idx_d  = slot_b_idx_q[col_d];
            out_b_nnz_d  = slot_b_nnz_q[col_d];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= LOAD_A;
            load_cnt_q   <= 2'd0;
            row_q        <= 2'd0;
            col_q        <= 2'd0;
            overrun_q    <= 1'b0;
            size_err_q   <= 1'b0;
            out_a_vals_q <= '0;
            out_a_idx_q  <= '0;
            out_a_nnz_q  <= '0;
            out_b_vals_q <= '0;
            out_b_idx_q  <= '0;
            out_b_nnz_q  <= '0;
        end else begin
            state_q      <= state_d;
            load_cnt_q   <= load_cnt_d;
            row_q        <= row_d;
            col_q        <= col_d;
            overrun_q    <= overrun_d;
            size_err_q   <= size_err_d;
            out_a_vals_q <= out_a_vals_d;
            out_a_idx_q  <= out_a_idx_d;
            out_a_nnz_q  <= out_a_nnz_d;
            out_b_vals_q <= out_b_vals_d;
            out_b_idx_q  <= out_b_idx_d;
            out_b_nnz_q  <= out_b_nnz_d;
        end
    end

    // Slot storage carries no reset; it is always fully rewritten before ISSUE.
    always_ff @(posedge clk) begin
        slot_a_vals_q <= slot_a_vals_d;
        slot_a_idx_q  <= slot_a_idx_d;
        slot_a_nnz_q  <= slot_a_nnz_d;
        slot_b_vals_q <= slot_b_vals_d;
        slot_b_idx_q  <= slot_b_idx_d;
        slot_b_nnz_q  <= slot_b_nnz_d;
    end

    assign out_valid = (state_q == ISSUE);
    assign busy      = (state_q == ISSUE) || (state_q == DONE);
    assign done      = (state_q == DONE);
    assign overrun   = overrun_q;
    assign size_err  = size_err_q;
    assign row       = row_q;
    assign col       = col_q;
    assign a_vals    = out_a_vals_q;
    assign a_idx     = out_a_idx_q;
    assign a_nnz     = out_a_nnz_q;
    assign b_vals    = out_b_vals_q;
    assign b_idx     = out_b_idx_q;
    assign b_nnz     = out_b_nnz_q;

endmodule
